murax_board_io_bridge: RTL and testbench

//  Board-side GPIO bridge between the Murax SoC gpioA port and board switches/LEDs.

---
 rtl/murax_io_pkg.sv | 17 +
 rtl/murax_board_io_bridge_debounce.sv | 50 +++++
 rtl/murax_board_io_bridge.sv | 96 +++++++++
 tb/tb_murax_board_io_bridge.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/murax_io_pkg.sv
// Shared constants and helpers for the Murax board I/O bridge.
package murax_io_pkg;

    localparam int PWM_OFF = 0;
    localparam int PWM_ON  = 1;

    // Number of bits needed to hold values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/murax_board_io_bridge_debounce.sv
// One switch channel: synchroniser chain, debounce counter and the accepted (stable) value.
import murax_io_pkg::*;

module murax_sw_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic stable_o,
    output logic update_o
);

    localparam int              CW       = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   sync_out;
    logic                   update;

    assign sync_out = sync_q[SYNC_STAGES-1];
    // The change is accepted on the edge that would complete the count.
    assign update   = (sync_out != stable_q) && (cnt_q == CNT_LAST);

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], sw_in};
        stable_d = update ? sync_out : stable_q;
        if (sync_out == stable_q || update) cnt_d = '0;
        else                                cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;
    assign update_o = update;

endmodule

// File: rtl/murax_board_io_bridge.sv
// Board-side gpioA bridge: debounced switches into gpio read, gpio write onto (optionally dimmed) LEDs.
import murax_io_pkg::*;

module murax_board_io_bridge #(
    parameter int GPIO_WIDTH      = 32,
    parameter int NUM_SW          = 16,
    parameter int NUM_LED         = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int PWM_EN          = PWM_ON,
    parameter int PWM_BITS        = 8
) (
    input  logic                  io_mainClk,
    input  logic                  io_reset,
    input  logic [NUM_SW-1:0]     sw,
    output logic [NUM_LED-1:0]    io_led,
    output logic [GPIO_WIDTH-1:0] io_gpioA_read,
    input  logic [GPIO_WIDTH-1:0] io_gpioA_write,
    input  logic [GPIO_WIDTH-1:0] io_gpioA_writeEn,
    input  logic [PWM_BITS-1:0]   led_duty,
    output logic                  sw_changed
);

    logic [NUM_SW-1:0]  stable;
    logic [NUM_SW-1:0]  update;
    logic               sw_changed_q, sw_changed_d;
    logic [NUM_LED-1:0] led_reg_q, led_reg_d;
    logic               unused_bits;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        murax_sw_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk     (io_mainClk),
            .rst     (io_reset),
            .sw_in   (sw[i]),
            .stable_o(stable[i]),
            .update_o(update[i])
        );
    end

    always_comb begin
        io_gpioA_read             = '0;
        io_gpioA_read[NUM_SW-1:0] = stable;
    end

    // Any number of channels updating together yields one pulse.
    always_comb begin
        sw_changed_d = |update;
        led_reg_d    = io_gpioA_write[NUM_LED-1:0] & io_gpioA_writeEn[NUM_LED-1:0];
    end

    always_ff @(posedge io_mainClk) begin
        if (io_reset) begin
            sw_changed_q <= 1'b0;
            led_reg_q    <= '0;
        end else begin
            sw_changed_q <= sw_changed_d;
            led_reg_q    <= led_reg_d;
        end
    end

    assign sw_changed  = sw_changed_q;
    assign unused_bits = ^{io_gpioA_write, io_gpioA_writeEn, led_duty};

    if (PWM_EN == PWM_ON) begin : g_pwm
        logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
        logic [PWM_BITS-1:0] duty_shadow_q, duty_shadow_d;
        logic [NUM_LED-1:0]  led_q, led_d;

        // Duty is only taken at the end of a period so a period is never cut short.
        always_comb begin
            pwm_cnt_d     = pwm_cnt_q + 1'b1;
            duty_shadow_d = (pwm_cnt_q == '1) ? led_duty : duty_shadow_q;
            led_d         = led_reg_q & {NUM_LED{pwm_cnt_q < duty_shadow_q}};
        end

        always_ff @(posedge io_mainClk) begin
            if (io_reset) begin
                pwm_cnt_q     <= '0;
                duty_shadow_q <= '1;
                led_q         <= '0;
            end else begin
                pwm_cnt_q     <= pwm_cnt_d;
                duty_shadow_q <= duty_shadow_d;
                led_q         <= led_d;
            end
        end

        assign io_led = led_q;
    end else begin : g_direct
        assign io_led = led_reg_q;
    end

endmodule

// File: tb/tb_murax_board_io_bridge.sv
// Directed + random bench for both LED modes, checked against a cycle-level behavioural model.
module tb_murax_board_io_bridge;

    localparam int SYNC = 2;
    localparam int DC   = 4;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic [3:0]  sw   = '0;
    logic [31:0] wr   = '0;
    logic [31:0] en   = '0;
    logic [2:0]  duty = '0;

    logic [3:0]  led_p, led_d;
    logic [31:0] rd_p, rd_d;
    logic        chg_p, chg_d;

    murax_board_io_bridge #(.GPIO_WIDTH(32), .NUM_SW(4), .NUM_LED(4), .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DC), .PWM_EN(1), .PWM_BITS(3)) dut_pwm (
        .io_mainClk(clk), .io_reset(rst), .sw(sw), .io_led(led_p), .io_gpioA_read(rd_p),
        .io_gpioA_write(wr), .io_gpioA_writeEn(en), .led_duty(duty), .sw_changed(chg_p));

    murax_board_io_bridge #(.GPIO_WIDTH(32), .NUM_SW(4), .NUM_LED(4), .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DC), .PWM_EN(0), .PWM_BITS(3)) dut_dir (
        .io_mainClk(clk), .io_reset(rst), .sw(sw), .io_led(led_d), .io_gpioA_read(rd_d),
        .io_gpioA_write(wr), .io_gpioA_writeEn(en), .led_duty(duty), .sw_changed(chg_d));

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Model state: pin history, per-channel run length of disagreement, accepted values, PWM phase.
    logic [3:0] m_hist [SYNC];
    int         m_run  [4];
    logic [3:0] m_stable;
    logic       m_chg;
    logic [3:0] m_led_reg, m_led_pwm;
    int         m_phase, m_duty;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_edge();
        logic [3:0] seen;
        if (rst) begin
            for (int j = 0; j < SYNC; j++) m_hist[j] = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_stable = '0; m_chg = 1'b0; m_led_reg = '0; m_led_pwm = '0;
            m_phase = 0; m_duty = 7;
        end else begin
            seen = m_hist[SYNC-1];
            for (int j = SYNC - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = sw;
            m_chg = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (seen[i] != m_stable[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DC) begin
                        m_stable[i] = seen[i];
                        m_run[i] = 0;
                        m_chg = 1'b1;
                    end
                end else m_run[i] = 0;
            end
            m_led_pwm = (m_phase < m_duty) ? m_led_reg : 4'h0;
            if (m_phase == 7) m_duty = int'(duty);
            m_phase = (m_phase + 1) % 8;
            m_led_reg = wr[3:0] & en[3:0];
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("read_pwm", rd_p, {28'h0, m_stable});
        chk("read_dir", rd_d, {28'h0, m_stable});
        chk("chg_pwm", 32'(chg_p), 32'(m_chg));
        chk("chg_dir", 32'(chg_d), 32'(m_chg));
        chk("led_pwm", 32'(led_p), 32'(m_led_pwm));
        chk("led_dir", 32'(led_d), 32'(m_led_reg));
    endtask

    int pulses, highs, odd;

    initial begin
        // Reset state
        step(); step();
        chk("rst_read", rd_p, 32'h0);
        chk("rst_led", 32'(led_p), 32'h0);
        chk("rst_chg", 32'(chg_p), 32'h0);

        // 1: switch 0 held high from reset release, accepted after SYNC+DC edges
        rst = 1'b0; sw = 4'b0001;
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            pulses += int'(chg_p);
            if (k == 5) chk("t1_read_early", rd_p, 32'h0);
            if (k == 6) begin chk("t1_read", rd_p, 32'h1); chk("t1_pulse", 32'(chg_p), 32'h1); end
        end
        chk("t1_pulses", 32'(pulses), 32'h1);

        // 2: 3-cycle glitch on switch 2 must be filtered
        sw = 4'b0101;
        step(); step(); step();
        sw = 4'b0001;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            pulses += int'(chg_p);
        end
        chk("t2_pulses", 32'(pulses), 32'h0);
        chk("t2_read", rd_p, 32'h1);

        // 3: three bits flip together -> one update edge, one pulse
        sw = 4'b1010;
        pulses = 0; odd = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            pulses += int'(chg_p);
            if (rd_p != 32'h1 && rd_p != 32'hA) odd++;
        end
        chk("t3_pulses", 32'(pulses), 32'h1);
        chk("t3_no_partial", 32'(odd), 32'h0);
        chk("t3_read", rd_p, 32'hA);

        // 4: write masked by writeEn, upper bits ignored
        wr = 32'hFFFF_FFFF; en = 32'hFFFF_FFF5;
        step();
        chk("t4_led_dir", 32'(led_d), 32'h5);

        // 5: duty change mid-period only applies after the wrap
        wr = 32'hF; en = 32'hF;
        for (int k = 0; k < 16 && m_phase != 4; k++) step();
        duty = 3'd3;
        for (int k = 0; k < 16 && m_duty != 3; k++) step();
        step();
        highs = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            highs += (led_p == 4'hF) ? 1 : 0;
        end
        chk("t5_duty3_highs", 32'(highs), 32'h3);
        duty = 3'd0;
        for (int k = 0; k < 16 && m_duty != 0; k++) step();
        step();
        highs = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            highs += (led_p != 4'h0) ? 1 : 0;
        end
        chk("t5_duty0_highs", 32'(highs), 32'h0);
        duty = 3'd5;

        // 6: reset mid-debounce and mid-PWM period
        sw = 4'b0101;
        step(); step(); step(); step();
        rst = 1'b1;
        step();
        chk("t6_read", rd_p, 32'h0);
        chk("t6_led_pwm", 32'(led_p), 32'h0);
        chk("t6_led_dir", 32'(led_d), 32'h0);
        chk("t6_chg", 32'(chg_p), 32'h0);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 5) chk("t6_restart_early", rd_p, 32'h0);
            if (k == 6) chk("t6_restart", rd_p, 32'h5);
        end

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 5) == 0) sw = 4'($urandom);
            wr = $urandom;
            en = $urandom;
            if ($urandom_range(0, 15) == 0) duty = 3'($urandom);
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
